coreaxitoahbl_wstrb_analyzer: RTL and testbench
===============================================

# coreaxitoahbl_wstrb_analyzer

Parametrised, registered successor to the AXI write-strobe population counter in the AXI-to-AHB-Lite bridge write path. It accepts one WSTRB beat per cycle over a valid/ready handshake and reports per-beat results: valid-byte count, lowest enabled byte lane, contiguity flag and empty flag. It also reports a running byte total across the burst, which restarts after WLAST. It sits between the AXI W-channel capture logic and the AHB transfer-size/address generator.

## Interface
- AXI_DWIDTH, 64, AXI data width; legal values 32, 64, 128.
- AXI_STRBWIDTH, AXI_DWIDTH/8, strobe width; must equal AXI_DWIDTH/8.
- BURST_CNT_WIDTH, 13, width of the burst byte accumulator; 13 covers 256 beats x 16 bytes.
- ACLK  input  1  clock; all logic is on the rising edge.
- ARESETN  input  1  reset; one clock, synchronous, active-low.
- WSTRBIn  input  AXI_STRBWIDTH  beat write strobe.
- WLASTIn  input  1  marks the last beat of a burst.
- inValid  input  1  beat presented.
- inReady  output  1  beat accepted when inValid && inReady.
- outValid  output  1  result registers hold an unconsumed result.
- outReady  input  1  downstream consumes the result.
- noValidBytes  output  clog2(AXI_STRBWIDTH)+1  popcount of the beat.
- firstByteOffset  output  clog2(AXI_STRBWIDTH)  index of the lowest set strobe bit.
- strbContig  output  1  set strobe bits form a single run.
- strbEmpty  output  1  beat strobe was all zero.
- beatLast  output  1  registered WLASTIn of the beat.
- burstBytes  output  BURST_CNT_WIDTH  cumulative bytes in the burst, including this beat.
- burstOvf  output  1  accumulator saturated during this burst.

## Operation
- Accept: inReady = !outValid || outReady. The block drives a single output register stage and has no skid buffer.
- On accept, all result outputs load from the combinational analysis of WSTRBIn, and outValid is set.
- Without an accept, outValid clears when outReady is high; otherwise all outputs hold stable.
- Popcount: sum of the WSTRBIn bits. Range is 0..AXI_STRBWIDTH; 16 is representable at AXI_DWIDTH=128.
- firstByteOffset: lowest index i with WSTRBIn[i]=1. It is 0 when the strobe is empty.
- strbContig: 1 when the set bits are one unbroken run. Empty strobe gives 1; all-ones gives 1; 8'b00100100 gives 0.
- strbEmpty: 1 when WSTRBIn==0; noValidBytes is then 0.
- Accumulator:
  - on accept, burstBytes = base + popcount, where base = 0 if the previously accepted beat had WLAST=1 (or no beat has been accepted since reset), otherwise the stored burstBytes;
  - saturates at 2^BURST_CNT_WIDTH-1;
  - burstOvf is set on saturation and stays set until the next burst starts.
- Simultaneous accept and consume in one cycle: the new result replaces the old with no bubble, giving full throughput.

## Timing
- Latency: 1 cycle from accepted beat to outValid.
- Throughput: 1 beat/cycle while outReady=1.
- Reset (ARESETN=0 at a rising edge):
  - outValid, noValidBytes, firstByteOffset, strbEmpty, beatLast, burstBytes and burstOvf go to 0;
  - strbContig goes to 1;
  - inReady is 1 from the first cycle after reset.
- Reset mid-burst discards the pending result and the accumulator; the next accepted beat starts a new burst.
- The block holds no state machine; the only state is the output register and the "next beat starts a burst" flag, which is 1 after reset and then set to the WLAST of each accepted beat.

## Configuration
- COREAXITOAHBL_WSTRB_CONTIG_CHK_EN:
  - defined: strbContig and firstByteOffset are computed as described above;
  - undefined: that logic is not built, strbContig is tied to 1 and firstByteOffset to 0. This is for bridges that only ever see aligned, full-width strobes.

## Structure
- Shared package coreaxitoahbl_pkg holds:
  - width functions POPCNT_W(strbw) and OFFSET_W(strbw);
  - the legal AXI_DWIDTH constants;
  - the result struct typedef {cnt, offset, contig, empty}.
- Sub-module coreaxitoahbl_wstrb_popcnt: purely combinational, parametrised by AXI_STRBWIDTH, returning the result struct. The top level holds the handshake, registers and accumulator.

## Test plan
- 64-bit, strobes 8'hFF, 8'h0F (WLAST) streamed with outReady=1 → noValidBytes 8 then 4; burstBytes 8 then 12; beatLast=1 on the second result; the next beat's burstBytes restarts from its own count.
- 64-bit, strobe 8'b00100100 → noValidBytes=2, firstByteOffset=2, strbContig=0; with the macro undefined, strbContig=1 and firstByteOffset=0.
- Strobe 8'h00 → strbEmpty=1, noValidBytes=0, strbContig=1, burstBytes unchanged.
- outReady held 0 for 5 cycles after one result → inReady=0 and outputs stable; outReady=1 with a new beat gives back-to-back results with no dropped or duplicated beat.
- AXI_DWIDTH=128, BURST_CNT_WIDTH=8, 17 beats of 16'hFFFF → burstBytes saturates at 255 with burstOvf=1; both clear on the first beat after WLAST.
- ARESETN low for 1 cycle after the third beat of a 4-beat burst → outputs at their reset values; the next beat with strobe 8'h03 reports burstBytes=2.

Source files
------------

// File: rtl/coreaxitoahbl_pkg.sv
// Shared types and width helpers for the AXI-to-AHB-Lite write-strobe path.
// Analysis result struct is sized for the widest (128-bit) data path.
package coreaxitoahbl_pkg;

  localparam int AXI_DW_32  = 32;
  localparam int AXI_DW_64  = 64;
  localparam int AXI_DW_128 = 128;

  function automatic int POPCNT_W(input int strbw);
    return $clog2(strbw) + 1;
  endfunction

  function automatic int OFFSET_W(input int strbw);
    return $clog2(strbw);
  endfunction

  typedef struct packed {
    logic [4:0] cnt;
    logic [3:0] offset;
    logic       contig;
    logic       empty;
  } wstrb_res_t;

endpackage

// File: rtl/coreaxitoahbl_wstrb_analyzer_if.sv
// Beat-in / result-out handshake bundle of the write-strobe analyzer.
// slave = analyzer side, master = W-channel capture / AHB generator side.
interface coreaxitoahbl_wstrb_analyzer_if #(
  parameter int STRBW = 8,
  parameter int BCW   = 13
);
  import coreaxitoahbl_pkg::*;

  localparam int CW = POPCNT_W(STRBW);
  localparam int OW = OFFSET_W(STRBW);

  logic [STRBW-1:0] WSTRBIn;
  logic             WLASTIn;
  logic             inValid;
  logic             inReady;
  logic             outValid;
  logic             outReady;
  logic [CW-1:0]    noValidBytes;
  logic [OW-1:0]    firstByteOffset;
  logic             strbContig;
  logic             strbEmpty;
  logic             beatLast;
  logic [BCW-1:0]   burstBytes;
  logic             burstOvf;

  modport slave (
    input  WSTRBIn, WLASTIn, inValid, outReady,
    output inReady, outValid, noValidBytes,
    output firstByteOffset, strbContig, strbEmpty,
    output beatLast, burstBytes, burstOvf
  );

  modport master (
    output WSTRBIn, WLASTIn, inValid, outReady,
    input  inReady, outValid, noValidBytes,
    input  firstByteOffset, strbContig, strbEmpty,
    input  beatLast, burstBytes, burstOvf
  );

endinterface

// File: rtl/coreaxitoahbl_wstrb_popcnt.sv
// Combinational strobe analysis: popcount, lowest lane, contiguity, empty.
// Offset/contiguity only built with COREAXITOAHBL_WSTRB_CONTIG_CHK_EN.
module coreaxitoahbl_wstrb_popcnt
  import coreaxitoahbl_pkg::*;
#(
  parameter int AXI_STRBWIDTH = 8
) (
  input  logic [AXI_STRBWIDTH-1:0] strb,
  output wstrb_res_t               res
);

`ifdef COREAXITOAHBL_WSTRB_CONTIG_CHK_EN
  logic [4:0] runs;
  logic       prev;
`endif

  always_comb begin
    res        = '0;
    res.contig = 1'b1;
    res.empty  = (strb == '0);
    for (int i = 0; i < AXI_STRBWIDTH; i++) begin
      res.cnt = res.cnt + 5'(strb[i]);
    end
`ifdef COREAXITOAHBL_WSTRB_CONTIG_CHK_EN
    runs = '0;
    prev = 1'b0;
    for (int i = AXI_STRBWIDTH - 1; i >= 0; i--) begin
      if (strb[i]) res.offset = 4'(i);
    end
    // A single run has exactly one 0->1 edge scanning upward.
    for (int i = 0; i < AXI_STRBWIDTH; i++) begin
      if (strb[i] && !prev) runs = runs + 5'd1;
      prev = strb[i];
    end
    res.contig = (runs <= 5'd1);
`endif
  end

endmodule

// File: rtl/coreaxitoahbl_wstrb_analyzer.sv
// Registered WSTRB analyzer with saturating per-burst byte accumulator.
// Optional macro: COREAXITOAHBL_WSTRB_CONTIG_CHK_EN (offset/contig logic).
module coreaxitoahbl_wstrb_analyzer
  import coreaxitoahbl_pkg::*;
#(
  parameter int AXI_DWIDTH      = 64,
  parameter int AXI_STRBWIDTH   = AXI_DWIDTH / 8,
  parameter int BURST_CNT_WIDTH = 13
) (
  input logic                          ACLK,
  input logic                          ARESETN,
  coreaxitoahbl_wstrb_analyzer_if.slave bus
);

  localparam int CW  = POPCNT_W(AXI_STRBWIDTH);
  localparam int OW  = OFFSET_W(AXI_STRBWIDTH);
  localparam int BCW = BURST_CNT_WIDTH;
  localparam int SW  = BCW + 1;

  localparam bit DW_OK = (AXI_DWIDTH == AXI_DW_32)
                      || (AXI_DWIDTH == AXI_DW_64)
                      || (AXI_DWIDTH == AXI_DW_128);

  if (!DW_OK || (AXI_STRBWIDTH != AXI_DWIDTH / 8)) begin : g_bad_cfg
    $error("illegal AXI_DWIDTH/AXI_STRBWIDTH");
  end

  wstrb_res_t res;

  coreaxitoahbl_wstrb_popcnt #(
    .AXI_STRBWIDTH(AXI_STRBWIDTH)
  ) u_popcnt (
    .strb(bus.WSTRBIn),
    .res (res)
  );

  logic unused_res;
  assign unused_res = ^res;

  logic           out_valid_q, out_valid_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [OW-1:0]  off_q, off_d;
  logic           contig_q, contig_d;
  logic           empty_q, empty_d;
  logic           last_q, last_d;
  logic [BCW-1:0] bytes_q, bytes_d;
  logic           ovf_q, ovf_d;
  logic           start_q, start_d;

  logic           in_ready;
  logic           accept;
  logic [BCW-1:0] base;
  logic [SW-1:0]  sum;

  assign in_ready = !out_valid_q || bus.outReady;
  assign accept   = bus.inValid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    off_d       = off_q;
    contig_d    = contig_q;
    empty_d     = empty_q;
    last_d      = last_q;
    bytes_d     = bytes_q;
    ovf_d       = ovf_q;
    start_d     = start_q;
    base        = start_q ? '0 : bytes_q;
    sum         = {1'b0, base} + SW'(res.cnt);
    if (accept) begin
      out_valid_d = 1'b1;
      cnt_d       = res.cnt[CW-1:0];
      off_d       = res.offset[OW-1:0];
      contig_d    = res.contig;
      empty_d     = res.empty;
      last_d      = bus.WLASTIn;
      start_d     = bus.WLASTIn;
      // Carry out of the accumulator means saturation.
      bytes_d     = sum[BCW] ? '1 : sum[BCW-1:0];
      ovf_d       = (!start_q && ovf_q) || sum[BCW];
    end else if (bus.outReady) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      off_q       <= '0;
      contig_q    <= 1'b1;
      empty_q     <= 1'b0;
      last_q      <= 1'b0;
      bytes_q     <= '0;
      ovf_q       <= 1'b0;
      start_q     <= 1'b1;
    end else begin
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      contig_q    <= contig_d;
      empty_q     <= empty_d;
      last_q      <= last_d;
      bytes_q     <= bytes_d;
      ovf_q       <= ovf_d;
      start_q     <= start_d;
    end
  end

  assign bus.inReady         = in_ready;
  assign bus.outValid        = out_valid_q;
  assign bus.noValidBytes    = cnt_q;
  assign bus.firstByteOffset = off_q;
  assign bus.strbContig      = contig_q;
  assign bus.strbEmpty       = empty_q;
  assign bus.beatLast        = last_q;
  assign bus.burstBytes      = bytes_q;
  assign bus.burstOvf        = ovf_q;

endmodule

// File: tb/tb_coreaxitoahbl_wstrb_analyzer.sv
// Bench: 64-bit and 128-bit analyzers checked against a burst-level model.
// Model honours COREAXITOAHBL_WSTRB_CONTIG_CHK_EN the same way as the build.
module tb_coreaxitoahbl_wstrb_analyzer;
  import coreaxitoahbl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  coreaxitoahbl_wstrb_analyzer_if #(.STRBW(8),  .BCW(13)) b64();
  coreaxitoahbl_wstrb_analyzer_if #(.STRBW(16), .BCW(8))  b128();

  coreaxitoahbl_wstrb_analyzer #(
    .AXI_DWIDTH(64), .BURST_CNT_WIDTH(13)
  ) dut64 (.ACLK(clk), .ARESETN(rst_n), .bus(b64.slave));

  coreaxitoahbl_wstrb_analyzer #(
    .AXI_DWIDTH(128), .BURST_CNT_WIDTH(8)
  ) dut128 (.ACLK(clk), .ARESETN(rst_n), .bus(b128.slave));

  typedef struct {
    bit valid;
    bit start;
    int bytes;
    bit ovf;
    int cnt;
    int off;
    bit contig;
    bit empty;
    bit last;
  } mst_t;

  mst_t m64, m128;

  function automatic mst_t m_reset();
    mst_t m = '{default: 0};
    m.start  = 1'b1;
    m.contig = 1'b1;
    return m;
  endfunction

  function automatic mst_t m_step(mst_t m, bit acc, bit ordy,
                                  int s, bit l, int bcw);
    int base, sum, maxv, low;
    if (acc) begin
      maxv    = (1 << bcw) - 1;
      base    = m.start ? 0 : m.bytes;
      sum     = base + $countones(s);
      m.ovf   = (m.start ? 1'b0 : m.ovf) || (sum > maxv);
      m.bytes = (sum > maxv) ? maxv : sum;
      m.cnt   = $countones(s);
      m.empty = (s == 0);
`ifdef COREAXITOAHBL_WSTRB_CONTIG_CHK_EN
      low      = s & -s;
      m.off    = (s == 0) ? 0 : $clog2(low);
      m.contig = (s == 0) ||
                 ((((s >> m.off) + 1) & (s >> m.off)) == 0);
`else
      low      = 0;
      m.off    = low;
      m.contig = 1'b1;
`endif
      m.last  = l;
      m.start = l;
      m.valid = 1'b1;
    end else if (ordy) begin
      m.valid = 1'b0;
    end
    return m;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_all(string p, mst_t m, logic ov,
                         logic [31:0] cnt, logic [31:0] off,
                         logic cg, logic em, logic la,
                         logic [31:0] bb, logic bo);
    chk({p, ".outValid"}, {31'd0, ov}, {31'd0, m.valid});
    chk({p, ".noValidBytes"}, cnt, m.cnt);
    chk({p, ".firstByteOffset"}, off, m.off);
    chk({p, ".strbContig"}, {31'd0, cg}, {31'd0, m.contig});
    chk({p, ".strbEmpty"}, {31'd0, em}, {31'd0, m.empty});
    chk({p, ".beatLast"}, {31'd0, la}, {31'd0, m.last});
    chk({p, ".burstBytes"}, bb, m.bytes);
    chk({p, ".burstOvf"}, {31'd0, bo}, {31'd0, m.ovf});
  endtask

  task automatic step64(bit v, logic [7:0] s, bit l, bit ordy);
    bit exp_rdy;
    b64.inValid  = v;
    b64.WSTRBIn  = s;
    b64.WLASTIn  = l;
    b64.outReady = ordy;
    #1;
    exp_rdy = !m64.valid || ordy;
    chk("64.inReady", {31'd0, b64.inReady}, {31'd0, exp_rdy});
    m64 = m_step(m64, v && exp_rdy, ordy, int'(s), l, 13);
    @(posedge clk);
    #1;
    cmp_all("64", m64, b64.outValid, b64.noValidBytes,
            b64.firstByteOffset, b64.strbContig, b64.strbEmpty,
            b64.beatLast, b64.burstBytes, b64.burstOvf);
  endtask

  task automatic step128(bit v, logic [15:0] s, bit l, bit ordy);
    bit exp_rdy;
    b128.inValid  = v;
    b128.WSTRBIn  = s;
    b128.WLASTIn  = l;
    b128.outReady = ordy;
    #1;
    exp_rdy = !m128.valid || ordy;
    chk("128.inReady", {31'd0, b128.inReady}, {31'd0, exp_rdy});
    m128 = m_step(m128, v && exp_rdy, ordy, int'(s), l, 8);
    @(posedge clk);
    #1;
    cmp_all("128", m128, b128.outValid, b128.noValidBytes,
            b128.firstByteOffset, b128.strbContig, b128.strbEmpty,
            b128.beatLast, b128.burstBytes, b128.burstOvf);
  endtask

  task automatic idle_all();
    b64.inValid   = 1'b0;
    b64.WSTRBIn   = '0;
    b64.WLASTIn   = 1'b0;
    b64.outReady  = 1'b0;
    b128.inValid  = 1'b0;
    b128.WSTRBIn  = '0;
    b128.WLASTIn  = 1'b0;
    b128.outReady = 1'b0;
  endtask

  task automatic do_reset();
    idle_all();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m64  = m_reset();
    m128 = m_reset();
    chk("rst.64.inReady", {31'd0, b64.inReady}, 32'd1);
    chk("rst.128.inReady", {31'd0, b128.inReady}, 32'd1);
    cmp_all("rst64", m64, b64.outValid, b64.noValidBytes,
            b64.firstByteOffset, b64.strbContig, b64.strbEmpty,
            b64.beatLast, b64.burstBytes, b64.burstOvf);
    cmp_all("rst128", m128, b128.outValid, b128.noValidBytes,
            b128.firstByteOffset, b128.strbContig, b128.strbEmpty,
            b128.beatLast, b128.burstBytes, b128.burstOvf);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rs;
    bit rv, rl, rr;
    do_reset();

    step64(1'b1, 8'hFF, 1'b0, 1'b1);
    chk("tp1.cnt0", 32'(b64.noValidBytes), 32'd8);
    chk("tp1.bytes0", 32'(b64.burstBytes), 32'd8);
    step64(1'b1, 8'h0F, 1'b1, 1'b1);
    chk("tp1.cnt1", 32'(b64.noValidBytes), 32'd4);
    chk("tp1.bytes1", 32'(b64.burstBytes), 32'd12);
    chk("tp1.last1", {31'd0, b64.beatLast}, 32'd1);
    step64(1'b1, 8'h03, 1'b0, 1'b1);
    chk("tp1.restart", 32'(b64.burstBytes), 32'd2);

    step64(1'b1, 8'b0010_0100, 1'b1, 1'b1);
    chk("tp2.cnt", 32'(b64.noValidBytes), 32'd2);
`ifdef COREAXITOAHBL_WSTRB_CONTIG_CHK_EN
    chk("tp2.off", 32'(b64.firstByteOffset), 32'd2);
    chk("tp2.contig", {31'd0, b64.strbContig}, 32'd0);
`else
    chk("tp2.off", 32'(b64.firstByteOffset), 32'd0);
    chk("tp2.contig", {31'd0, b64.strbContig}, 32'd1);
`endif

    step64(1'b1, 8'h03, 1'b0, 1'b1);
    step64(1'b1, 8'h00, 1'b0, 1'b1);
    chk("tp3.empty", {31'd0, b64.strbEmpty}, 32'd1);
    chk("tp3.bytes", 32'(b64.burstBytes), 32'd2);
    step64(1'b1, 8'h01, 1'b1, 1'b1);

    step64(1'b1, 8'hF0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step64(1'b1, 8'($urandom), 1'b0, 1'b0);
    end
    chk("tp4.held", 32'(b64.burstBytes), 32'd4);
    step64(1'b1, 8'h3C, 1'b1, 1'b1);
    step64(1'b1, 8'hFF, 1'b0, 1'b1);
    step64(1'b0, 8'h00, 1'b0, 1'b1);

    for (int i = 0; i < 400; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 3) != 0);
      rl = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      step64(rv, rs, rl, rr);
    end
    step64(1'b0, 8'h00, 1'b0, 1'b1);
    idle_all();

    for (int i = 0; i < 17; i++) begin
      step128(1'b1, 16'hFFFF, (i == 16), 1'b1);
    end
    chk("tp5.sat", 32'(b128.burstBytes), 32'd255);
    chk("tp5.ovf", {31'd0, b128.burstOvf}, 32'd1);
    step128(1'b1, 16'h000F, 1'b0, 1'b1);
    chk("tp5.clr.bytes", 32'(b128.burstBytes), 32'd4);
    chk("tp5.clr.ovf", {31'd0, b128.burstOvf}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      step128(($urandom_range(0, 3) != 0), 16'($urandom),
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 3) != 0));
    end
    step128(1'b0, 16'h0000, 1'b0, 1'b1);
    idle_all();

    step64(1'b1, 8'hFF, 1'b0, 1'b1);
    step64(1'b1, 8'hFF, 1'b0, 1'b1);
    step64(1'b1, 8'hFF, 1'b0, 1'b1);
    do_reset();
    step64(1'b1, 8'h03, 1'b1, 1'b1);
    chk("tp6.bytes", 32'(b64.burstBytes), 32'd2);
    step64(1'b0, 8'h00, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
